audio_softmute: RTL and testbench



---
 rtl/audio_softmute.sv | 147 ++++++++++++++
 tb/tb_audio_softmute.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/audio_softmute.sv
// audio_softmute: click-free stereo mute/unmute.
// Samples the core audio on a decimated tick, scales it by a 9-bit linear
// gain that ramps between 0 and 256 (unity), and presents registered
// samples with a one-cycle valid strobe two cycles after the tick.
module audio_softmute #(
    parameter int WIDTH  = 16,
    parameter int CE_DIV = 1750,
    parameter int STEP   = 1
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    mute,
    input  logic signed [WIDTH-1:0] in_l,
    input  logic signed [WIDTH-1:0] in_r,
    output logic signed [WIDTH-1:0] out_l,
    output logic signed [WIDTH-1:0] out_r,
    output logic                    out_valid,
    output logic                    muted
);

    localparam int             DW         = $clog2(CE_DIV);
    localparam logic [DW-1:0]  LP_DIV_MAX = DW'(CE_DIV - 1);
    localparam logic [9:0]     LP_STEP    = 10'(STEP);
    localparam logic [9:0]     LP_UNITY   = 10'd256;

    localparam logic [1:0] ST_MUTED  = 2'd0;
    localparam logic [1:0] ST_UP     = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DOWN   = 2'd3;

    logic                    r_mute_meta, r_mute_s;
    logic [DW-1:0]           r_div;
    logic [1:0]              r_state;
    logic [8:0]              r_g;
    logic [8:0]              r_g_s;
    logic signed [WIDTH-1:0] r_smp_l, r_smp_r;
    // [0]: sample captured (S1 busy), [1]: outputs just updated
    logic [1:0]              r_vld_pipe;

    logic                    w_tick;
    logic [9:0]              w_g10, w_g_inc, w_g_dec;
    logic signed [WIDTH+8:0] w_a_l, w_a_r, w_gx, w_p_l, w_p_r;
    logic                    w_unused;

    assign w_tick = (r_div == LP_DIV_MAX);

    // Saturating gain steps, evaluated in 10 bits so 256+STEP cannot wrap
    assign w_g10   = {1'b0, r_g};
    assign w_g_inc = ((w_g10 + LP_STEP) > LP_UNITY) ? LP_UNITY : (w_g10 + LP_STEP);
    assign w_g_dec = (w_g10 > LP_STEP) ? (w_g10 - LP_STEP) : 10'd0;

    // Sample x gain; gain is zero-extended so 256 stays positive
    assign w_a_l = {{9{r_smp_l[WIDTH-1]}}, r_smp_l};
    assign w_a_r = {{9{r_smp_r[WIDTH-1]}}, r_smp_r};
    assign w_gx  = {{WIDTH{1'b0}}, r_g_s};
    assign w_p_l = w_a_l * w_gx;
    assign w_p_r = w_a_r * w_gx;

    // Bits dropped by the >>>8 and the guard bit that can never differ from sign
    assign w_unused = ^{w_p_l[WIDTH+8], w_p_l[7:0], w_p_r[WIDTH+8], w_p_r[7:0]};

    assign out_valid = r_vld_pipe[1];
    assign muted     = (r_state == ST_MUTED);

    // Two-flop synchronizer; resets to "muted" so power-up is silent
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mute_meta <= 1'b1;
            r_mute_s    <= 1'b1;
        end else begin
            r_mute_meta <= mute;
            r_mute_s    <= r_mute_meta;
        end
    end

    // Sample-rate divider producing one tick every CE_DIV cycles
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_div <= '0;
        else          r_div <= w_tick ? '0 : r_div + DW'(1);
    end

    // Ramp FSM; gain and state only move on a tick
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_MUTED;
            r_g     <= 9'd0;
        end else if (w_tick) begin
            case (r_state)
                ST_MUTED: if (!r_mute_s) begin
                    r_state <= ST_UP;
                    r_g     <= w_g_inc[8:0];
                end
                ST_UP: if (r_mute_s) begin
                    r_state <= ST_DOWN;
                    r_g     <= w_g_dec[8:0];
                end else begin
                    r_g <= w_g_inc[8:0];
                    if (w_g_inc == LP_UNITY) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: if (r_mute_s) begin
                    r_state <= ST_DOWN;
                    r_g     <= w_g_dec[8:0];
                end
                ST_DOWN: if (!r_mute_s) begin
                    r_state <= ST_UP;
                    r_g     <= w_g_inc[8:0];
                end else begin
                    r_g <= w_g_dec[8:0];
                    if (w_g_dec == 10'd0) r_state <= ST_MUTED;
                end
                default: begin
                    r_state <= ST_MUTED;
                    r_g     <= 9'd0;
                end
            endcase
        end
    end

    // S0: capture samples and the pre-update gain on the tick
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_smp_l <= '0;
            r_smp_r <= '0;
            r_g_s   <= 9'd0;
        end else if (w_tick) begin
            r_smp_l <= in_l;
            r_smp_r <= in_r;
            r_g_s   <= r_g;
        end
    end

    // S1->S2: scale, floor-shift by 8 and register outputs with valid strobe
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= 2'b00;
            out_l      <= '0;
            out_r      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_tick};
            if (r_vld_pipe[0]) begin
                out_l <= w_p_l[WIDTH+7:8];
                out_r <= w_p_r[WIDTH+7:8];
            end
        end
    end

endmodule

// File: tb/tb_audio_softmute.sv
// Bench for audio_softmute: directed ramp/reversal/reset scenarios plus
// randomized audio and mute traffic against a saturating-gain reference model.
module tb_audio_softmute;

    localparam int W  = 16;
    localparam int CD = 4;
    localparam int ST = 64;

    logic                clk_sys = 1'b0;
    logic                reset_n = 1'b0;
    logic                mute    = 1'b0;
    logic signed [W-1:0] in_l    = '0;
    logic signed [W-1:0] in_r    = '0;
    logic signed [W-1:0] out_l, out_r;
    logic                out_valid, muted;

    audio_softmute #(.WIDTH(W), .CE_DIV(CD), .STEP(ST)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .mute(mute),
        .in_l(in_l), .in_r(in_r),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .muted(muted)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: gain is a saturating integrator of +/-STEP per tick,
    // driven by the mute request delayed two clocks.
    int  m_g, m_run, cyc, pl, pr, pg, e_l, e_r, last_v;
    bit  m_never, sq0, sq1, pend, e_v;
    int  q_l[$], q_r[$];

    function automatic int fl256(input int p);
        return (p >= 0) ? p / 256 : -((-p + 255) / 256);
    endfunction

    // Silent only once gain is 0 and mute has been held for two ticks in a row
    function automatic bit e_muted();
        return (m_g == 0) && (m_never || m_run >= 2);
    endfunction

    task automatic model_reset();
        m_g = 0; m_run = 0; m_never = 1; sq0 = 1; sq1 = 1;
        cyc = 0; pend = 0; e_l = 0; e_r = 0; e_v = 0; last_v = -1;
    endtask

    task automatic model_edge();
        bit ms;
        ms = sq1; sq1 = sq0; sq0 = mute;
        if (pend) begin
            e_l = fl256(pl * pg); e_r = fl256(pr * pg); e_v = 1; pend = 0;
        end else e_v = 0;
        if (cyc % CD == CD - 1) begin
            pend = 1; pl = in_l; pr = in_r; pg = m_g;
            if (ms) begin
                m_g = (m_g > ST) ? m_g - ST : 0; m_run++;
            end else begin
                m_g = (m_g + ST > 256) ? 256 : m_g + ST; m_run = 0; m_never = 0;
            end
        end
        cyc++;
    endtask

    // One clock: predict the edge, then check everything at the falling edge
    task automatic step();
        model_edge();
        @(negedge clk_sys);
        chk("out_valid", int'(out_valid), int'(e_v));
        chk("muted", int'(muted), int'(e_muted()));
        chk("out_l", int'(out_l), e_l);
        chk("out_r", int'(out_r), e_r);
        if (out_valid) begin
            if (last_v >= 0) chk("period", cyc - last_v, CD);
            last_v = cyc;
            q_l.push_back(int'(out_l));
            q_r.push_back(int'(out_r));
        end
    endtask

    initial begin
        int first_v, n;
        int ramp[6] = '{0, 4096, 8192, 12288, 16384, 16384};
        int rev[5]  = '{128, 192, 128, 64, 0};

        // Reset state with live clock and full-scale input
        reset_n = 1'b0; mute = 1'b0; in_l = 16'sh7FFF; in_r = 16'sh7FFF;
        repeat (3) @(negedge clk_sys);
        chk("rst_out_l", int'(out_l), 0);
        chk("rst_out_r", int'(out_r), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_muted", int'(muted), 1);

        // Ramp up from reset
        model_reset();
        in_l = 16'sd16384; in_r = -16'sd16384;
        reset_n = 1'b1;
        q_l.delete(); q_r.delete(); first_v = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid && first_v < 0) first_v = cyc;
        end
        chk("first_valid_cycle", first_v, CD + 1);
        chk("ramp_count_ok", int'(q_l.size() >= 6), 1);
        if (q_l.size() >= 6)
            for (int i = 0; i < 6; i++) begin
                chk("ramp_l", q_l[i], ramp[i]);
                chk("ramp_r", q_r[i], -ramp[i]);
            end

        // Mid-ramp reversal at gain 192
        mute = 1'b1;
        n = 0; while (!e_muted() && n < 400) begin step(); n++; end
        chk("wait_muted", int'(e_muted()), 1);
        mute = 1'b0; in_l = 16'sd256; in_r = 16'sd256;
        n = 0; while (!(m_g == 192 && pend) && n < 400) begin step(); n++; end
        chk("wait_g192", int'(m_g == 192 && pend), 1);
        q_l.delete(); q_r.delete();
        mute = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("rev_count_ok", int'(q_l.size() >= 5), 1);
        if (q_l.size() >= 5)
            for (int i = 0; i < 5; i++) chk("rev_l", q_l[i], rev[i]);
        chk("rev_muted", int'(muted), 1);

        // Unity: ramp fully up, then random audio for 1000 ticks
        mute = 1'b0;
        n = 0; while (m_g != 256 && n < 400) begin step(); n++; end
        chk("wait_unity", m_g, 256);
        for (int i = 0; i < 1000 * CD; i++) begin
            in_l = W'($urandom); in_r = W'($urandom);
            step();
        end

        // Random mute toggling with random audio
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(23, 0) == 0) mute = ~mute;
            in_l = W'($urandom); in_r = W'($urandom);
            step();
        end

        // Async reset while a captured sample is in flight at gain 128
        mute = 1'b1; in_l = 16'sd256; in_r = 16'sd256;
        n = 0; while (!e_muted() && n < 400) begin step(); n++; end
        chk("wait_muted2", int'(e_muted()), 1);
        mute = 1'b0;
        n = 0; while (!(m_g == 128 && pend) && n < 400) begin step(); n++; end
        chk("wait_g128", int'(m_g == 128 && pend), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_l", int'(out_l), 0);
        chk("arst_out_r", int'(out_r), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_muted", int'(muted), 1);
        repeat (2) begin
            @(negedge clk_sys);
            chk("arst_no_valid", int'(out_valid), 0);
        end

        // Restart from zero gain; also exercises floor rounding of negatives
        model_reset();
        in_l = -16'sd1; in_r = -16'sd3;
        q_l.delete(); q_r.delete();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("restart_count_ok", int'(q_l.size() >= 3), 1);
        if (q_l.size() >= 3) begin
            chk("restart_l0", q_l[0], 0);  chk("restart_r0", q_r[0], 0);
            chk("floor_l_g64", q_l[1], -1); chk("floor_r_g64", q_r[1], -1);
            chk("floor_l_g128", q_l[2], -1); chk("floor_r_g128", q_r[2], -2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
